pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
- Program-counter register and instruction-fetch sequencer for the single-cycle core.
- Drives the current PC into the PC+4 adder and consumes that adder's sum, together with the branch-target and jump-target values, to select the next PC.
- Fetches each instruction from instruction memory over a req/ack handshake, then presents it to decode until decode releases it.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be word-aligned.
- CNT_W, 32, width of the issued-instruction counter.

Ports:
- clk  in  1  core clock; all state updates on its rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- pc_o  out  32  current PC, registered; wired to the A input of the PC+4 adder.
- pc_plus4_i  in  32  sum from the PC+4 adder (pc_o + 4).
- branch_taken_i  in  1  decode/ALU says the branch is taken.
- branch_target_i  in  32  branch target address.
- jump_i  in  1  unconditional jump.
- jump_target_i  in  32  jump target address.
- stall_i  in  1  decode is not ready to consume instr_o.
- imem_req_o  out  1  fetch request.
- imem_addr_o  out  32  fetch address (equals pc_o).
- imem_ack_i  in  1  memory returns data this cycle.
- imem_rdata_i  in  32  instruction word.
- instr_o  out  32  latched instruction.
- instr_valid_o  out  1  instr_o is valid for decode.
- misalign_o  out  1  sticky flag: a misaligned next PC was selected.
- issue_cnt_o  out  CNT_W  number of instructions released to decode.

Behaviour:
- Reset: when rst_n=0 at a clock edge, the next state is RST.
  - Outputs: pc_o=RESET_PC, imem_req_o=0, instr_o=0, instr_valid_o=0, misalign_o=0, issue_cnt_o=0.
  - Reset applies in any state. An imem_ack_i in the same cycle is ignored, and any in-flight fetch is abandoned.
- State RST: entered on reset; moves unconditionally to FETCH on the first edge with rst_n=1.
- State FETCH:
  - imem_req_o=1 and imem_addr_o=pc_o, both combinational from state.
  - On imem_ack_i=1: instr_o<=imem_rdata_i, instr_valid_o<=1, then go to ISSUE.
  - Otherwise stay in FETCH with pc_o, address and req held stable.
- State ISSUE:
  - imem_req_o=0 and instr_valid_o=1.
  - If stall_i=1: hold everything.
  - If stall_i=0: pc_o<=next_pc, instr_valid_o<=0, issue_cnt_o increments by 1, then go to FETCH.
  - issue_cnt_o wraps from all-ones to 0.
- next_pc is a combinational priority select, sampled only in ISSUE with stall_i=0:
  - jump_i=1 gives jump_target_i;
  - else branch_taken_i=1 gives branch_target_i;
  - else pc_plus4_i.
  - Jump has priority when jump_i and branch_taken_i are both 1.
- Misalignment: if next_pc[1:0]!=0 at the release edge:
  - pc_o is not updated, misalign_o<=1, issue_cnt_o still increments, and the next state is ERR.
  - ERR: imem_req_o=0, instr_valid_o=0, all registers held. Only reset leaves ERR.
- Ignored inputs:
  - imem_ack_i outside FETCH;
  - stall_i outside ISSUE;
  - branch/jump inputs outside ISSUE.
- Wrap-around: pc_plus4_i=0 when PC=32'hFFFF_FFFC. PC becomes 0 with no error.
- Latency:
  - First request is asserted in the first cycle after reset release.
  - ack in cycle k gives instr_valid_o=1 in cycle k+1.
  - With a zero-wait memory (ack same cycle as req) and no stall, throughput is one instruction per 2 cycles.
- No combinational path from imem_ack_i or imem_rdata_i to any output.

Decomposition:
- Shared package/header cpu_defs: state encoding (RST=2'd0, FETCH=2'd1, ISSUE=2'd2, ERR=2'd3), default RESET_PC, word-alignment mask 2'b00.
- One sub-module, next_pc_sel (combinational): priority mux plus alignment check.
  - Inputs: pc_plus4, branch, jump.
  - Outputs: next_pc, misaligned.
- FSM, PC register, instruction latch and counter stay in pc_fetch_unit.

Test Plan:
1. Reset, then release rst_n; memory acks 3 cycles after each req with rdata=32'h0000_0013; stall_i=0 -> imem_addr_o sequence 0x0, 0x4, 0x8; instr_valid_o high for one cycle per fetch; issue_cnt_o reaches 3 after the third release.
2. In ISSUE, assert stall_i for 4 cycles -> instr_valid_o and instr_o held; pc_o and issue_cnt_o unchanged; no req. On stall_i=0 the PC advances by 4.
3. In ISSUE with branch_taken_i=1, branch_target_i=0x100, jump_i=1, jump_target_i=0x200 -> next pc_o=0x200. With branch only -> pc_o=0x100.
4. branch_target_i=0x102 taken -> misalign_o=1, pc_o unchanged, state ERR, imem_req_o stays 0 until rst_n pulsed low, after which pc_o=RESET_PC and misalign_o=0.
5. Drive rst_n=0 in FETCH in the same cycle as imem_ack_i=1 -> instr_valid_o stays 0, instr_o=0, pc_o=RESET_PC.
6. Force PC to 0xFFFF_FFFC (RESET_PC override); the adder returns 0 -> pc_o=0x0, misalign_o=0, fetch continues at 0x0.

Source files
------------

// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the fetch sequencer: FSM encoding, reset PC default
// and the word-alignment rule used by the next-PC selector.
package cpu_defs;

    localparam logic [1:0] ST_RST   = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_ISSUE = 2'd2;
    localparam logic [1:0] ST_ERR   = 2'd3;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [1:0]  WORD_ALIGN_MASK  = 2'b00;

    function automatic logic is_word_aligned(input logic [31:0] addr);
        return addr[1:0] == WORD_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/pc_fetch_unit_next_pc_sel.sv
// Next-PC priority select (jump > branch > sequential) with alignment check.
module next_pc_sel
    import cpu_defs::*;
(
    input  logic [31:0] pc_plus4,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic [31:0] next_pc,
    output logic        misaligned
);

    logic [31:0] w_sel;

    always_comb begin
        w_sel = pc_plus4;
        if (jump)
            w_sel = jump_target;
        else if (branch_taken)
            w_sel = branch_target;
    end

    assign next_pc    = w_sel;
    assign misaligned = !is_word_aligned(w_sel);

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register and fetch/issue sequencer: fetches over a req/ack handshake,
// holds the word for decode until released, then advances the PC.
module pc_fetch_unit
    import cpu_defs::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [31:0]      pc_o,
    input  logic [31:0]      pc_plus4_i,
    input  logic             branch_taken_i,
    input  logic [31:0]      branch_target_i,
    input  logic             jump_i,
    input  logic [31:0]      jump_target_i,
    input  logic             stall_i,
    output logic             imem_req_o,
    output logic [31:0]      imem_addr_o,
    input  logic             imem_ack_i,
    input  logic [31:0]      imem_rdata_i,
    output logic [31:0]      instr_o,
    output logic             instr_valid_o,
    output logic             misalign_o,
    output logic [CNT_W-1:0] issue_cnt_o
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [1:0]       r_state;
    logic [31:0]      r_pc;
    logic [31:0]      r_instr;
    logic             r_instr_valid;
    logic             r_misalign;
    logic [CNT_W-1:0] r_cnt;

    logic [31:0]      w_next_pc;
    logic             w_misaligned;

    next_pc_sel u_next_pc_sel (
        .pc_plus4      (pc_plus4_i),
        .branch_taken  (branch_taken_i),
        .branch_target (branch_target_i),
        .jump          (jump_i),
        .jump_target   (jump_target_i),
        .next_pc       (w_next_pc),
        .misaligned    (w_misaligned)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_RST;
            r_pc          <= RESET_PC;
            r_instr       <= '0;
            r_instr_valid <= 1'b0;
            r_misalign    <= 1'b0;
            r_cnt         <= '0;
        end else begin
            case (r_state)
                ST_RST: r_state <= ST_FETCH;
                ST_FETCH: begin
                    if (imem_ack_i) begin
                        r_instr       <= imem_rdata_i;
                        r_instr_valid <= 1'b1;
                        r_state       <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (!stall_i) begin
                        r_instr_valid <= 1'b0;
                        r_cnt         <= r_cnt + CNT_ONE;
                        // A bad target still counts as released, but the PC
                        // keeps the address of the offending instruction.
                        if (w_misaligned) begin
                            r_misalign <= 1'b1;
                            r_state    <= ST_ERR;
                        end else begin
                            r_pc    <= w_next_pc;
                            r_state <= ST_FETCH;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign pc_o          = r_pc;
    assign imem_req_o    = (r_state == ST_FETCH);
    assign imem_addr_o   = r_pc;
    assign instr_o       = r_instr;
    assign instr_valid_o = r_instr_valid;
    assign misalign_o    = r_misalign;
    assign issue_cnt_o   = r_cnt;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Transaction-level bench for pc_fetch_unit: a memory responder and decode
// driver per instruction, compared against an expected-PC/count model.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        branch_taken, jump, stall, ack;
    logic [31:0] branch_target, jump_target, rdata;

    logic [31:0] pc0, pc_plus4_0, addr0, instr0;
    logic        req0, vld0, mis0;
    logic [31:0] cnt0;

    logic [31:0] pc1, pc_plus4_1, addr1, instr1;
    logic        req1, vld1, mis1;
    logic [31:0] cnt1;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] exp_pc, exp_instr, exp_cnt;
    logic        exp_mis;

    always #5 clk = ~clk;

    // External PC+4 adders
    assign pc_plus4_0 = pc0 + 32'd4;
    assign pc_plus4_1 = pc1 + 32'd4;

    pc_fetch_unit #(.RESET_PC(32'h0000_0000), .CNT_W(32)) dut0 (
        .clk(clk), .rst_n(rst_n), .pc_o(pc0), .pc_plus4_i(pc_plus4_0),
        .branch_taken_i(branch_taken), .branch_target_i(branch_target),
        .jump_i(jump), .jump_target_i(jump_target), .stall_i(stall),
        .imem_req_o(req0), .imem_addr_o(addr0), .imem_ack_i(ack),
        .imem_rdata_i(rdata), .instr_o(instr0), .instr_valid_o(vld0),
        .misalign_o(mis0), .issue_cnt_o(cnt0)
    );

    pc_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .CNT_W(32)) dut1 (
        .clk(clk), .rst_n(rst_n), .pc_o(pc1), .pc_plus4_i(pc_plus4_1),
        .branch_taken_i(branch_taken), .branch_target_i(branch_target),
        .jump_i(jump), .jump_target_i(jump_target), .stall_i(stall),
        .imem_req_o(req1), .imem_addr_o(addr1), .imem_ack_i(ack),
        .imem_rdata_i(rdata), .instr_o(instr1), .instr_valid_o(vld1),
        .misalign_o(mis1), .issue_cnt_o(cnt1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_redirect();
        jump = 1'b0; branch_taken = 1'b0;
        jump_target = $urandom; branch_target = $urandom;
    endtask

    // Reset pulse, leaving the DUT one cycle into FETCH
    task automatic pulse_reset();
        rst_n = 1'b0; stall = 1'b0; ack = 1'b0; clear_redirect();
        tick();
        rst_n = 1'b1;
        tick();
        exp_pc = 32'h0; exp_instr = 32'h0; exp_cnt = 32'h0; exp_mis = 1'b0;
    endtask

    // One instruction: fetch with `lat` wait cycles, `stalls` decode stalls,
    // then release with the given redirect inputs.
    task automatic do_fetch(input int lat, input logic [31:0] data, input int stalls,
                            input logic jv, input logic [31:0] jt,
                            input logic bv, input logic [31:0] bt, input string tag);
        logic [31:0] nxt;
        n_checks++;
        if (req0 !== 1'b1 || addr0 !== exp_pc) begin
            n_errors++;
            $display("FAIL %s req/addr: got req=%b addr=%h, exp req=1 addr=%h", tag, req0, addr0, exp_pc);
        end
        for (int i = 0; i < lat; i++) begin
            ack = 1'b0; rdata = $urandom; stall = $urandom_range(0, 1);
            tick();
            n_checks++;
            if (req0 !== 1'b1 || addr0 !== exp_pc || vld0 !== 1'b0) begin
                n_errors++;
                $display("FAIL %s wait: got req=%b addr=%h vld=%b, exp 1/%h/0", tag, req0, addr0, vld0, exp_pc);
            end
        end
        ack = 1'b1; rdata = data; stall = 1'b1;
        tick();
        ack = 1'b0; rdata = $urandom;
        exp_instr = data;
        n_checks++;
        if (vld0 !== 1'b1 || instr0 !== exp_instr || req0 !== 1'b0) begin
            n_errors++;
            $display("FAIL %s latch: got vld=%b instr=%h req=%b, exp 1/%h/0", tag, vld0, instr0, req0, exp_instr);
        end
        for (int i = 0; i < stalls; i++) begin
            stall = 1'b1; ack = $urandom_range(0, 1);
            jump = $urandom_range(0, 1); jump_target = $urandom;
            tick();
            n_checks++;
            if (vld0 !== 1'b1 || instr0 !== exp_instr || pc0 !== exp_pc ||
                cnt0 !== exp_cnt || req0 !== 1'b0) begin
                n_errors++;
                $display("FAIL %s stall: got vld=%b instr=%h pc=%h cnt=%0d req=%b, exp 1/%h/%h/%0d/0",
                         tag, vld0, instr0, pc0, cnt0, req0, exp_instr, exp_pc, exp_cnt);
            end
        end
        stall = 1'b0; ack = 1'b0;
        jump = jv; jump_target = jt; branch_taken = bv; branch_target = bt;
        nxt = jv ? jt : (bv ? bt : exp_pc + 32'd4);
        tick();
        clear_redirect();
        exp_cnt = exp_cnt + 32'd1;
        if (nxt[1:0] != 2'b00) exp_mis = 1'b1;
        else exp_pc = nxt;
        n_checks++;
        if (pc0 !== exp_pc || cnt0 !== exp_cnt || mis0 !== exp_mis || vld0 !== 1'b0 ||
            req0 !== !exp_mis) begin
            n_errors++;
            $display("FAIL %s release: got pc=%h cnt=%0d mis=%b vld=%b req=%b, exp %h/%0d/%b/0/%b",
                     tag, pc0, cnt0, mis0, vld0, req0, exp_pc, exp_cnt, exp_mis, !exp_mis);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ack = 1'b1; rdata = 32'hDEAD_BEEF; stall = 1'b0; clear_redirect();
        tick(); tick();
        n_checks++;
        if (pc0 !== 32'h0 || req0 !== 1'b0 || instr0 !== 32'h0 || vld0 !== 1'b0 ||
            mis0 !== 1'b0 || cnt0 !== 32'h0) begin
            n_errors++;
            $display("FAIL reset_state: got pc=%h req=%b instr=%h vld=%b mis=%b cnt=%0d, exp all zero",
                     pc0, req0, instr0, vld0, mis0, cnt0);
        end
        ack = 1'b0; rst_n = 1'b1;
        tick();
        exp_pc = 32'h0; exp_instr = 32'h0; exp_cnt = 32'h0; exp_mis = 1'b0;
        n_checks++;
        if (req0 !== 1'b1 || addr0 !== 32'h0) begin
            n_errors++;
            $display("FAIL first_req: got req=%b addr=%h, exp 1/00000000", req0, addr0);
        end
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 3; i++)
            do_fetch(3, 32'h0000_0013, 0, 1'b0, 32'h0, 1'b0, 32'h0, "seq");
        n_checks++;
        if (cnt0 !== 32'd3 || pc0 !== 32'hC) begin
            n_errors++;
            $display("FAIL seq_total: got cnt=%0d pc=%h, exp 3/0000000c", cnt0, pc0);
        end
    endtask

    task automatic test_stall();
        do_fetch(1, $urandom, 4, 1'b0, 32'h0, 1'b0, 32'h0, "stall4");
    endtask

    task automatic test_redirect();
        do_fetch(0, $urandom, 0, 1'b1, 32'h200, 1'b1, 32'h100, "jump_prio");
        do_fetch(2, $urandom, 1, 1'b0, 32'h0,   1'b1, 32'h100, "branch");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 40; i++)
            do_fetch($urandom_range(0, 3), $urandom, $urandom_range(0, 3),
                     1'(($urandom_range(0, 3) == 0)), $urandom & 32'hFFFF_FFFC,
                     1'(($urandom_range(0, 2) == 0)), $urandom & 32'hFFFF_FFFC, "random");
    endtask

    task automatic test_misalign();
        do_fetch(1, 32'h0000_0063, 0, 1'b0, 32'h0, 1'b1, 32'h102, "misalign");
        for (int i = 0; i < 5; i++) begin
            ack = 1'b1; stall = $urandom_range(0, 1); jump = 1'b1; jump_target = 32'h40;
            tick();
            n_checks++;
            if (req0 !== 1'b0 || vld0 !== 1'b0 || mis0 !== 1'b1 || pc0 !== exp_pc || cnt0 !== exp_cnt) begin
                n_errors++;
                $display("FAIL err_hold: got req=%b vld=%b mis=%b pc=%h cnt=%0d, exp 0/0/1/%h/%0d",
                         req0, vld0, mis0, pc0, cnt0, exp_pc, exp_cnt);
            end
        end
        clear_redirect(); ack = 1'b0;
        pulse_reset();
        n_checks++;
        if (pc0 !== 32'h0 || mis0 !== 1'b0 || req0 !== 1'b1 || cnt0 !== 32'h0) begin
            n_errors++;
            $display("FAIL err_exit: got pc=%h mis=%b req=%b cnt=%0d, exp 0/0/1/0", pc0, mis0, req0, cnt0);
        end
    endtask

    task automatic test_reset_with_ack();
        do_fetch(0, 32'h1234_5678, 0, 1'b0, 32'h0, 1'b0, 32'h0, "pre_rst");
        rst_n = 1'b0; ack = 1'b1; rdata = 32'hCAFE_F00D;
        tick();
        ack = 1'b0;
        n_checks++;
        if (vld0 !== 1'b0 || instr0 !== 32'h0 || pc0 !== 32'h0 || req0 !== 1'b0) begin
            n_errors++;
            $display("FAIL rst_ack: got vld=%b instr=%h pc=%h req=%b, exp 0/0/0/0", vld0, instr0, pc0, req0);
        end
        rst_n = 1'b1;
        tick();
        exp_pc = 32'h0; exp_instr = 32'h0; exp_cnt = 32'h0; exp_mis = 1'b0;
    endtask

    task automatic test_pc_wrap();
        pulse_reset();
        n_checks++;
        if (req1 !== 1'b1 || addr1 !== 32'hFFFF_FFFC) begin
            n_errors++;
            $display("FAIL wrap_start: got req=%b addr=%h, exp 1/fffffffc", req1, addr1);
        end
        ack = 1'b1; rdata = 32'h0000_0013;
        tick();
        ack = 1'b0; stall = 1'b0;
        tick();
        n_checks++;
        if (pc1 !== 32'h0 || mis1 !== 1'b0 || req1 !== 1'b1 || addr1 !== 32'h0 || cnt1 !== 32'd1) begin
            n_errors++;
            $display("FAIL wrap: got pc=%h mis=%b req=%b addr=%h cnt=%0d, exp 0/0/1/0/1",
                     pc1, mis1, req1, addr1, cnt1);
        end
        ack = 1'b1; rdata = 32'h0040_0093;
        tick();
        ack = 1'b0;
        n_checks++;
        if (vld1 !== 1'b1 || instr1 !== 32'h0040_0093 || pc1 !== 32'h0) begin
            n_errors++;
            $display("FAIL wrap_fetch: got vld=%b instr=%h pc=%h, exp 1/00400093/0", vld1, instr1, pc1);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_back_to_back();
        test_misalign();
        test_reset_with_ack();
        test_pc_wrap();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
